// File: rtl/mbist_pkg.sv
// Shared definitions for the MBIST blanket generator/checker pair:
// default widths, checker FSM encoding and small width helpers.
package mbist_pkg;

    localparam int DEF_DW     = 4;
    localparam int DEF_AW     = 8;
    localparam int DEF_CW     = 8;
    localparam int MAX_RD_LAT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bits needed to hold the values 0..n (never less than one bit).
    function automatic int bits_for(input int n);
        return (n <= 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/blanket_checker_if.sv
// Tap bundle between the blanket generator / memory and the response checker,
// plus the checker's result outputs and a debug view of its FSM state.
interface blanket_checker_if
    import mbist_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW,
    parameter int CW = DEF_CW
);
    // No valid/ready here: a beat is qualified by en_in, and it is a read beat
    // when w_en_in=0; rd_dat_in carries that beat's data RD_LAT cycles later.
    logic          en_in;
    logic [DW-1:0] exp_dat_in;
    logic [AW-1:0] addr_in;
    logic          w_en_in;
    logic          done_in;
    logic [DW-1:0] rd_dat_in;

    logic          fail_out;
    logic [AW-1:0] fail_addr_out;
    logic [DW-1:0] fail_syn_out;
    logic [DW-1:0] fail_mask_out;
    logic [CW-1:0] err_cnt_out;
    logic          done_out;
    logic          pass_out;
    state_t        state_dbg;

    modport master (
        output en_in, exp_dat_in, addr_in, w_en_in, done_in, rd_dat_in,
        input  fail_out, fail_addr_out, fail_syn_out, fail_mask_out,
               err_cnt_out, done_out, pass_out, state_dbg
    );

    modport slave (
        input  en_in, exp_dat_in, addr_in, w_en_in, done_in, rd_dat_in,
        output fail_out, fail_addr_out, fail_syn_out, fail_mask_out,
               err_cnt_out, done_out, pass_out, state_dbg
    );

endinterface

// File: rtl/mbist_rd_pipe.sv
// DEPTH-stage delay line for {valid, addr, expected data}; flush clears the
// valids synchronously so in-flight read beats are dropped.
module mbist_rd_pipe #(
    parameter int AW    = 8,
    parameter int DW    = 4,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_exp,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_exp
);

    logic [DEPTH-1:0] vld_q;
    logic [AW-1:0]    addr_q [DEPTH];
    logic [DW-1:0]    exp_q  [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
            end
        end else begin
            vld_q[0]  <= in_valid & ~flush;
            addr_q[0] <= in_addr;
            exp_q[0]  <= in_exp;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]  <= vld_q[i-1] & ~flush;
                addr_q[i] <= addr_q[i-1];
                exp_q[i]  <= exp_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_addr  = addr_q[DEPTH-1];
    assign out_exp   = exp_q[DEPTH-1];

endmodule

// File: rtl/blanket_checker.sv
// MBIST response analyzer: delays each read beat's address/expected data by
// RD_LAT, compares against memory read data and accumulates failure results.
module blanket_checker
    import mbist_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int CW     = DEF_CW,
    parameter int RD_LAT = 1
) (
    input logic             clk,
    input logic             rst,
    blanket_checker_if.slave bus
);

    localparam int DCW = bits_for(RD_LAT);

    state_t         state, state_nxt;
    logic [DCW-1:0] drain_cnt;
    logic           drain_last;

    logic           push_vld, pipe_flush, done_o, pass_o;
    logic           p_vld;
    logic [AW-1:0]  p_addr;
    logic [DW-1:0]  p_exp;
    logic [DW-1:0]  syn;
    logic           active, start, hit;

    logic           fail_q;
    logic [AW-1:0]  fail_addr_q;
    logic [DW-1:0]  fail_syn_q;
    logic [DW-1:0]  fail_mask_q;
    logic [CW-1:0]  err_cnt_q;

    assign active     = (state == RUN) || (state == DRAIN);
    assign start      = (state == IDLE) && bus.en_in;
    assign drain_last = (drain_cnt == DCW'(RD_LAT - 1));
    assign syn        = p_exp ^ bus.rd_dat_in;
    // Beats reaching the compare point on an abort edge are discarded too.
    assign hit        = p_vld && active && bus.en_in && (syn != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.en_in) state_nxt = RUN;
            RUN:     if (!bus.en_in) state_nxt = IDLE;
                     else if (bus.done_in) state_nxt = DRAIN;
            DRAIN:   if (!bus.en_in) state_nxt = IDLE;
                     else if (drain_last) state_nxt = DONE;
            DONE:    if (!bus.en_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        done_o     = (state == DONE);
        pass_o     = (state == DONE) && !fail_q;
        push_vld   = (state == RUN) && bus.en_in && !bus.w_en_in;
        pipe_flush = active && !bus.en_in;
    end

    // Counts cycles spent in DRAIN so the last in-flight beat gets compared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  drain_cnt <= '0;
        else if (state != DRAIN)  drain_cnt <= '0;
        else                      drain_cnt <= drain_cnt + 1'b1;
    end

    mbist_rd_pipe #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (RD_LAT)
    ) u_rd_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (pipe_flush),
        .in_valid  (push_vld),
        .in_addr   (bus.addr_in),
        .in_exp    (bus.exp_dat_in),
        .out_valid (p_vld),
        .out_addr  (p_addr),
        .out_exp   (p_exp)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_syn_q  <= '0;
            fail_mask_q <= '0;
            err_cnt_q   <= '0;
        end else if (start) begin
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_syn_q  <= '0;
            fail_mask_q <= '0;
            err_cnt_q   <= '0;
        end else if (hit) begin
            fail_q      <= 1'b1;
            fail_mask_q <= fail_mask_q | syn;
            if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
            if (!fail_q) begin
                fail_addr_q <= p_addr;
                fail_syn_q  <= syn;
            end
        end
    end

    assign bus.fail_out      = fail_q;
    assign bus.fail_addr_out = fail_addr_q;
    assign bus.fail_syn_out  = fail_syn_q;
    assign bus.fail_mask_out = fail_mask_q;
    assign bus.err_cnt_out   = err_cnt_q;
    assign bus.done_out      = done_o;
    assign bus.pass_out      = pass_o;
    assign bus.state_dbg     = state;

endmodule

// File: tb/tb_blanket_checker.sv
// Bench for blanket_checker: two instances (RD_LAT=1 and RD_LAT=3) share one
// generator stimulus and a behavioural memory with per-address read corruption.
module tb_blanket_checker;
    import mbist_pkg::*;

    typedef struct packed {
        logic       done;
        logic       pass;
        logic       fail;
        logic [7:0] addr;
        logic [3:0] syn;
        logic [3:0] mask;
        logic [7:0] cnt;
    } res_t;

    typedef struct {
        logic [3:0] pat;
        logic [7:0] fa0;
        logic [3:0] ff0;
        logic [7:0] fa1;
        logic [3:0] ff1;
        logic       flip_all;
        int         nreads;
        res_t       want;
    } vec_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       en_s   = 1'b0;
    logic       w_s    = 1'b0;
    logic       done_s = 1'b0;
    logic [7:0] addr_s = 8'h00;
    logic [3:0] exp_s  = 4'h0;

    logic [3:0] mem     [256];
    logic [3:0] flip    [256];
    logic [3:0] rd_pipe [3];

    always @(posedge clk) begin
        if (en_s && w_s) mem[addr_s] <= exp_s;
        rd_pipe[0] <= (en_s && !w_s) ? (mem[addr_s] ^ flip[addr_s]) : 4'h0;
        rd_pipe[1] <= rd_pipe[0];
        rd_pipe[2] <= rd_pipe[1];
    end

    blanket_checker_if #(.DW(4), .AW(8), .CW(8)) bus1 ();
    blanket_checker_if #(.DW(4), .AW(8), .CW(8)) bus3 ();

    assign bus1.en_in      = en_s;
    assign bus1.w_en_in    = w_s;
    assign bus1.done_in    = done_s;
    assign bus1.addr_in    = addr_s;
    assign bus1.exp_dat_in = exp_s;
    assign bus1.rd_dat_in  = rd_pipe[0];
    assign bus3.en_in      = en_s;
    assign bus3.w_en_in    = w_s;
    assign bus3.done_in    = done_s;
    assign bus3.addr_in    = addr_s;
    assign bus3.exp_dat_in = exp_s;
    assign bus3.rd_dat_in  = rd_pipe[2];

    blanket_checker #(.DW(4), .AW(8), .CW(8), .RD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    blanket_checker #(.DW(4), .AW(8), .CW(8), .RD_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.slave)
    );

    res_t res1, res3;
    assign res1 = {bus1.done_out, bus1.pass_out, bus1.fail_out, bus1.fail_addr_out,
                   bus1.fail_syn_out, bus1.fail_mask_out, bus1.err_cnt_out};
    assign res3 = {bus3.done_out, bus3.pass_out, bus3.fail_out, bus3.fail_addr_out,
                   bus3.fail_syn_out, bus3.fail_mask_out, bus3.err_cnt_out};

    // scoreboard
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic chk_res(input string tag, input res_t act, input res_t want);
        chk({tag, ".done"}, 32'(act.done), 32'(want.done));
        chk({tag, ".pass"}, 32'(act.pass), 32'(want.pass));
        chk({tag, ".fail"}, 32'(act.fail), 32'(want.fail));
        chk({tag, ".addr"}, 32'(act.addr), 32'(want.addr));
        chk({tag, ".syn"},  32'(act.syn),  32'(want.syn));
        chk({tag, ".mask"}, 32'(act.mask), 32'(want.mask));
        chk({tag, ".cnt"},  32'(act.cnt),  32'(want.cnt));
    endtask

    function automatic res_t mk_res(input logic done, input logic fail, input logic [7:0] a,
                                    input logic [3:0] s, input logic [3:0] m, input logic [7:0] c);
        return {done, done & ~fail, fail, a, s, m, c};
    endfunction

    // driver
    task automatic drive(input logic en, input logic w, input logic [7:0] a,
                         input logic [3:0] d, input logic dn);
        en_s   = en;
        w_s    = w;
        addr_s = a;
        exp_s  = d;
        done_s = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic write_pass(input logic [3:0] pat);
        for (int a = 0; a < 256; a++) drive(1'b1, 1'b1, 8'(a), pat, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        res_t  idle_want;
        tag = $sformatf("v%0d", idx);
        for (int a = 0; a < 256; a++) flip[a] = v.flip_all ? v.ff0 : 4'h0;
        if (!v.flip_all) begin
            flip[v.fa0] = v.ff0;
            flip[v.fa1] = flip[v.fa1] | v.ff1;
        end
        write_pass(v.pat);
        // done_in rides on the final read beat
        for (int i = 0; i < v.nreads; i++)
            drive(1'b1, 1'b0, 8'(i % 256), v.pat, i == v.nreads - 1);
        drive(1'b1, 1'b1, 8'h00, v.pat, 1'b0);
        chk({tag, ".lat1_done"}, 32'(bus1.done_out), 32'd1);
        chk({tag, ".lat3_early1"}, 32'(bus3.done_out), 32'd0);
        drive(1'b1, 1'b1, 8'h00, v.pat, 1'b0);
        chk({tag, ".lat3_early2"}, 32'(bus3.done_out), 32'd0);
        drive(1'b1, 1'b1, 8'h00, v.pat, 1'b0);
        chk({tag, ".lat3_done"}, 32'(bus3.done_out), 32'd1);
        chk({tag, ".lat3_state"}, 32'(bus3.state_dbg), 32'(DONE));
        chk_res({tag, ".r1"}, res1, v.want);
        chk_res({tag, ".r3"}, res3, v.want);
        drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        idle_want      = v.want;
        idle_want.done = 1'b0;
        idle_want.pass = 1'b0;
        chk_res({tag, ".idle1"}, res1, idle_want);
        chk_res({tag, ".idle3"}, res3, idle_want);
        drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b1);
        chk({tag, ".ign_done1"}, 32'(bus1.done_out), 32'd0);
        chk({tag, ".ign_done3"}, 32'(bus3.done_out), 32'd0);
    endtask

    vec_t vecs [6];
    res_t ab_want;

    initial begin
        //           pat    fa0    ff0    fa1    ff1   all  nrd  done  fail addr   syn   mask  cnt
        vecs[0] = '{4'hA, 8'h00, 4'h0, 8'h00, 4'h0, 1'b0, 256, mk_res(1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 8'h00)};
        vecs[1] = '{4'hF, 8'h5A, 4'h4, 8'h00, 4'h0, 1'b0, 256, mk_res(1'b1, 1'b1, 8'h5A, 4'h4, 4'h4, 8'h01)};
        vecs[2] = '{4'h3, 8'h10, 4'h1, 8'h20, 4'h8, 1'b0, 256, mk_res(1'b1, 1'b1, 8'h10, 4'h1, 4'h9, 8'h02)};
        vecs[3] = '{4'h0, 8'h00, 4'h6, 8'h00, 4'h0, 1'b1, 300, mk_res(1'b1, 1'b1, 8'h00, 4'h6, 4'h6, 8'hFF)};
        vecs[4] = '{4'h9, 8'hFF, 4'h2, 8'h00, 4'h0, 1'b0, 256, mk_res(1'b1, 1'b1, 8'hFF, 4'h2, 4'h2, 8'h01)};
        vecs[5] = '{4'hC, 8'h05, 4'h3, 8'h00, 4'h0, 1'b0, 300, mk_res(1'b1, 1'b1, 8'h05, 4'h3, 4'h3, 8'h02)};

        repeat (2) @(posedge clk);
        #1;
        chk_res("reset1", res1, '0);
        chk_res("reset3", res3, '0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Abort mid-run with the corrupted beat at 0x30 still in flight.
        for (int a = 0; a < 256; a++) flip[a] = 4'h0;
        flip[8'h20] = 4'h2;
        flip[8'h30] = 4'h1;
        write_pass(4'h7);
        for (int i = 0; i <= 8'h30; i++) drive(1'b1, 1'b0, 8'(i), 4'h7, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 4'h0, 1'b0);
        ab_want = mk_res(1'b0, 1'b1, 8'h20, 4'h2, 4'h2, 8'h01);
        chk_res("abort1", res1, ab_want);
        chk_res("abort3", res3, ab_want);
        chk("abort3.state", 32'(bus3.state_dbg), 32'(IDLE));

        // Immediate restart: results clear, and flushed beats must not reappear.
        drive(1'b1, 1'b1, 8'h00, 4'h7, 1'b0);
        chk_res("restart1", res1, '0);
        chk_res("restart3", res3, '0);
        write_pass(4'h7);
        for (int i = 0; i <= 8'h25; i++) drive(1'b1, 1'b0, 8'(i), 4'h7, 1'b0);
        chk_res("rerun1", res1, ab_want);
        chk_res("rerun3", res3, ab_want);

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b1;
        #1;
        chk_res("async_rst1", res1, '0);
        chk_res("async_rst3", res3, '0);
        chk("async_rst3.state", 32'(bus3.state_dbg), 32'(IDLE));
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/blanket_checker.md
Name: blanket_checker

Overview:
- MBIST response analyzer; the read-side counterpart of the blanket pattern generator.
- Taps the generator's expected data, address and write-enable, plus the memory's read data returned RD_LAT cycles later.
- Compares every read beat and records first-failure address/syndrome, a cumulative fail mask and a saturating error count.
- Reports pass/fail when the generator signals pass completion.

Parameters:
- DW, 4, data width (matches generator dat_out)
- AW, 8, address width (matches generator addr_out)
- CW, 8, error counter width
- RD_LAT, 1, memory read latency in cycles (legal 1..4)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en_in  in  1  test enable (same signal driving the generator)
- exp_dat_in  in  DW  expected data from generator (dat_out)
- addr_in  in  AW  address from generator (addr_out)
- w_en_in  in  1  generator write enable; 0 while en_in=1 means read beat
- done_in  in  1  generator pass complete (rst_done)
- rd_dat_in  in  DW  memory read data, valid RD_LAT cycles after its read beat
- fail_out  out  1  sticky: at least one mismatch this run
- fail_addr_out  out  AW  address of first mismatch
- fail_syn_out  out  DW  exp XOR rd of first mismatch
- fail_mask_out  out  DW  OR of all mismatch syndromes this run
- err_cnt_out  out  CW  mismatching read beats, saturates at all-ones
- done_out  out  1  run finished, results final
- pass_out  out  1  done_out AND NOT fail_out

Behaviour:
- Reset (async, any state):
  - All outputs 0; FSM to IDLE; pipeline valids cleared.
  - Mid-run reset discards all results.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: outputs hold last results. en_in=1 -> RUN; in the same edge, clear fail_out, fail_addr_out, fail_syn_out, fail_mask_out, err_cnt_out.
  - RUN: every cycle with en_in=1, w_en_in=0 pushes {valid=1, addr_in, exp_dat_in} into an RD_LAT-deep delay line; other cycles push valid=0.
  - RUN, done_in=1 -> DRAIN. A read beat in the same cycle as done_in is still pushed.
  - DRAIN: pushes valid=0; stays exactly RD_LAT cycles, then -> DONE.
  - DONE: done_out=1, pass_out=~fail_out; held until en_in=0 -> IDLE. done_out falls on that edge; result registers are retained.
  - RUN or DRAIN with en_in=0: abort to IDLE. Delay line flushed (valids cleared), so in-flight beats are not compared. Results so far retained; done_out stays 0.
- Compare:
  - When the delay-line output valid=1, syn = exp XOR rd_dat_in.
  - If syn != 0:
    - err_cnt_out increments (saturates at 2^CW-1, no wrap).
    - fail_mask_out |= syn.
    - If fail_out was 0: capture fail_addr_out=addr, fail_syn_out=syn. First failure only; later failures do not overwrite.
    - fail_out set on the same edge.
  - Result registers update 1 cycle after the data appears at rd_dat_in.
  - Compare is active in RUN and DRAIN only.
- Latency: read beat at edge N -> rd_dat_in sampled at edge N+RD_LAT -> outputs visible after that edge.
- Address wrap (255 -> 0) needs no special handling; duplicate addresses are compared independently.
- done_in asserted while in IDLE or DONE: ignored.

Decomposition:
- Shared package mbist_pkg:
  - DW, AW, CW defaults
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3
  - Width helpers, shared with the generator
- One sub-module: mbist_rd_pipe. A parameterised RD_LAT-stage delay line for {valid, addr, exp} with a synchronous flush input. The checker instantiates one.

Test Plan:
- Fault-free run, RD_LAT=1: memory model returns written data; drive a full 256-address write pass then a read pass, done_in=1 -> done_out=1, pass_out=1, err_cnt_out=0, fail_mask_out=4'h0.
- Single stuck bit: memory bit 2 stuck-at-0 at addr 8'h5A, expected 4'hF -> fail_out=1, fail_addr_out=8'h5A, fail_syn_out=4'h4, err_cnt_out=1, pass_out=0.
- Multiple faults: mismatches at 8'h10 (syn 4'h1) then 8'h20 (syn 4'h8) -> fail_addr_out=8'h10, fail_syn_out=4'h1, fail_mask_out=4'h9, err_cnt_out=2.
- Saturation: CW=8 with every read wrong across 300 read beats -> err_cnt_out=8'hFF, no wrap.
- Latency/boundary: RD_LAT=3, final read beat coincident with done_in, last read corrupted -> error counted, done_out rises exactly 3 cycles after DRAIN entry.
- Abort/reset: en_in dropped mid-RUN with a corrupted read in flight -> that beat not counted, done_out=0. Then assert rst mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.
